alu_result_fifo: RTL

//   Downstream capture stage for the 4-op ALU decoder. That decoder rotates its op

---
 rtl/alu_result_fifo.sv | 83 ++++++++
 1 files changed

// File: rtl/alu_result_fifo.sv
// Capture stage behind the rotating 4-op ALU decoder.
// Each valid result is tagged with the current op phase and buffered in a FIFO with registered head outputs.
module alu_result_fifo #(
    parameter int         WIDTH   = 8,
    parameter int         DEPTH   = 8,
    parameter logic [3:0] OP_MASK = 4'b1111
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           result,
    input  logic                       in_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [1:0]                 out_op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [1:0]       phase;
    logic [WIDTH+1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_next;
    logic [CW-1:0]    count_next;
    logic [WIDTH+1:0] head_next;
    logic             push_req;
    logic             push;
    logic             pop;

    assign out_valid = (count != '0);

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        push_req   = in_valid & OP_MASK[phase];
        pop        = out_valid & out_ready;
        push       = push_req & ((count < CW'(DEPTH)) | pop);
        rd_next    = pop ? rd_ptr + AW'(1) : rd_ptr;
        count_next = count;
        unique case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
        // The new head may be the entry being written at this very edge.
        if (push && (rd_next == wr_ptr))
            head_next = {phase, result};
        else
            head_next = mem[rd_next];
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {phase, result};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= 2'd0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            out_data <= '0;
            out_op   <= 2'd0;
        end else begin
            phase  <= phase + 2'd1;
            rd_ptr <= rd_next;
            count  <= count_next;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (push_req && !push)
                overflow <= 1'b1;
            // Outputs keep their last value once the FIFO runs empty.
            if (count_next != '0)
                {out_op, out_data} <= head_next;
        end
    end

endmodule
